idu_mt: RTL and testbench

Parametrised multi-thread RV32I decode stage sitting between the fetch unit and the execute unit. Decodes the full RV32I base set into a per-instruction control word with sign-extended immediates, and carries pc and thread id alongside. A valid/ready handshake with a 2-entry skid buffer provides back-pressure. Per-thread flush and a per-thread halt-on-illegal state are added on top of that.

---
 rtl/idu_pkg.sv | 79 +++++++
 rtl/idu_dec_core.sv | 126 ++++++++++++
 rtl/idu_mt.sv | 122 ++++++++++++
 tb/tb_idu_mt.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/idu_pkg.sv
// Shared types for the multi-thread RV32I decode stage: opcodes, operation
// classes, immediate formats and the decoded control word.
package idu_pkg;

  // Immediate width carried in the control word (RV32I base set).
  localparam int IMM_W = 32;

  // RV32I major opcodes (instr[6:0]).
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Operation class handed to execute; CLS_NONE is used for illegal words.
  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_LUI    = 4'd1,
    CLS_AUIPC  = 4'd2,
    CLS_JAL    = 4'd3,
    CLS_JALR   = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_LOAD   = 4'd6,
    CLS_STORE  = 4'd7,
    CLS_OP_IMM = 4'd8,
    CLS_OP     = 4'd9,
    CLS_FENCE  = 4'd10,
    CLS_SYSTEM = 4'd11
  } op_class_t;

  // Immediate encodings; IMM_SH is the shift-immediate shamt field.
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_SH   = 3'd6
  } imm_fmt_t;

  typedef struct packed {
    logic             rs1_en;
    logic             rs2_en;
    logic             rd_en;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [4:0]       rd_addr;
    logic [IMM_W-1:0] imm;
    op_class_t        op_class;
    logic [2:0]       fn3;
    logic             alt;
    logic             illegal;
  } decoded_t;

  // Sign-extended immediate for the given format; B and J keep bit0 at 0.
  function automatic logic [IMM_W-1:0] imm_gen(input logic [31:0] ins,
                                               input imm_fmt_t fmt);
    logic [IMM_W-1:0] imm;
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      IMM_SH:  imm = {27'b0, ins[24:20]};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/idu_dec_core.sv
// Combinational RV32I decoder: instruction word to decoded control word.
module idu_dec_core
  import idu_pkg::*;
(
  input  logic [31:0] i_instr,
  output decoded_t    o_dec
);

  logic       w_legal;
  logic       w_use_rs1;
  logic       w_use_rs2;
  logic       w_use_rd;
  imm_fmt_t   w_fmt;
  op_class_t  w_cls;
  logic [2:0] w_fn3;
  logic [6:0] w_fn7;
  logic [4:0] w_rd;

  assign w_fn3 = i_instr[14:12];
  assign w_fn7 = i_instr[31:25];
  assign w_rd  = i_instr[11:7];

  // Classify the opcode, validate fn3/funct7 and pick register usage and imm format.
  always_comb begin
    w_legal   = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    w_fmt     = IMM_NONE;
    w_cls     = CLS_NONE;
    if (i_instr[1:0] == 2'b11) begin
      case (i_instr[6:0])
        OPC_LUI: begin
          w_legal = 1'b1; w_cls = CLS_LUI; w_use_rd = 1'b1; w_fmt = IMM_U;
        end
        OPC_AUIPC: begin
          w_legal = 1'b1; w_cls = CLS_AUIPC; w_use_rd = 1'b1; w_fmt = IMM_U;
        end
        OPC_JAL: begin
          w_legal = 1'b1; w_cls = CLS_JAL; w_use_rd = 1'b1; w_fmt = IMM_J;
        end
        OPC_JALR: begin
          w_legal   = (w_fn3 == 3'b000);
          w_cls     = CLS_JALR;
          w_use_rd  = 1'b1;
          w_use_rs1 = 1'b1;
          w_fmt     = IMM_I;
        end
        OPC_BRANCH: begin
          w_legal   = (w_fn3 != 3'b010) && (w_fn3 != 3'b011);
          w_cls     = CLS_BRANCH;
          w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1;
          w_fmt     = IMM_B;
        end
        OPC_LOAD: begin
          w_legal   = (w_fn3 == 3'b000) || (w_fn3 == 3'b001) || (w_fn3 == 3'b010) ||
                      (w_fn3 == 3'b100) || (w_fn3 == 3'b101);
          w_cls     = CLS_LOAD;
          w_use_rd  = 1'b1;
          w_use_rs1 = 1'b1;
          w_fmt     = IMM_I;
        end
        OPC_STORE: begin
          w_legal   = (w_fn3 == 3'b000) || (w_fn3 == 3'b001) || (w_fn3 == 3'b010);
          w_cls     = CLS_STORE;
          w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1;
          w_fmt     = IMM_S;
        end
        OPC_OP_IMM: begin
          w_cls     = CLS_OP_IMM;
          w_use_rd  = 1'b1;
          w_use_rs1 = 1'b1;
          if (w_fn3 == 3'b001) begin
            w_legal = (w_fn7 == 7'b0000000);
            w_fmt   = IMM_SH;
          end else if (w_fn3 == 3'b101) begin
            w_legal = (w_fn7 == 7'b0000000) || (w_fn7 == 7'b0100000);
            w_fmt   = IMM_SH;
          end else begin
            w_legal = 1'b1;
            w_fmt   = IMM_I;
          end
        end
        OPC_OP: begin
          w_cls     = CLS_OP;
          w_use_rd  = 1'b1;
          w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1;
          w_legal   = (w_fn7 == 7'b0000000) ||
                      ((w_fn7 == 7'b0100000) && ((w_fn3 == 3'b000) || (w_fn3 == 3'b101)));
        end
        OPC_FENCE: begin
          w_legal = (w_fn3 == 3'b000);
          w_cls   = CLS_FENCE;
        end
        OPC_SYSTEM: begin
          w_legal = (i_instr == 32'h0000_0073) || (i_instr == 32'h0010_0073);
          w_cls   = CLS_SYSTEM;
        end
        default: w_legal = 1'b0;
      endcase
    end
  end

  // Assemble the control word; unused fields and every field of an illegal word are zero.
  always_comb begin
    o_dec = '0;
    if (w_legal) begin
      o_dec.rs1_en   = w_use_rs1;
      o_dec.rs1_addr = w_use_rs1 ? i_instr[19:15] : 5'd0;
      o_dec.rs2_en   = w_use_rs2;
      o_dec.rs2_addr = w_use_rs2 ? i_instr[24:20] : 5'd0;
      o_dec.rd_en    = w_use_rd && (w_rd != 5'd0);
      o_dec.rd_addr  = w_use_rd ? w_rd : 5'd0;
      o_dec.imm      = imm_gen(i_instr, w_fmt);
      o_dec.op_class = w_cls;
      o_dec.fn3      = w_fn3;
      o_dec.alt      = i_instr[30];
    end else begin
      o_dec.illegal  = 1'b1;
    end
  end

endmodule

// File: rtl/idu_mt.sv
// Multi-thread decode stage: decoder, output register plus skid register,
// per-thread flush and per-thread halt-on-illegal.
module idu_mt
  import idu_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int THREADS = 4,
  localparam int TID_W   = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TID_W-1:0] in_tid,
  input  logic             flush,
  input  logic [TID_W-1:0] flush_tid,
  output logic             out_valid,
  input  logic             out_ready,
  output decoded_t         out_dec,
  output logic [XLEN-1:0]  out_pc,
  output logic [TID_W-1:0] out_tid
);

  logic               r_out_valid;
  decoded_t           r_out_dec;
  logic [XLEN-1:0]    r_out_pc;
  logic [TID_W-1:0]   r_out_tid;
  logic               r_skid_valid;
  decoded_t           r_skid_dec;
  logic [XLEN-1:0]    r_skid_pc;
  logic [TID_W-1:0]   r_skid_tid;
  logic [THREADS-1:0] r_halted;

  decoded_t w_dec;
  logic     w_halt_hit;
  logic     w_push;
  logic     w_pop;
  logic     w_out_hit;
  logic     w_skid_hit;
  logic     w_keep_out;
  logic     w_keep_skid;

  idu_dec_core u_dec (
    .i_instr (in_instr),
    .o_dec   (w_dec)
  );

  // Only registered state feeds in_ready, so out_ready never reaches it combinationally.
  assign in_ready  = !r_skid_valid && !rst;
  assign out_valid = r_out_valid;
  assign out_dec   = r_out_dec;
  assign out_pc    = r_out_pc;
  assign out_tid   = r_out_tid;

  // Work out which buffered entries survive this cycle and whether the input is kept.
  always_comb begin
    w_halt_hit = 1'b0;
    for (int unsigned t = 0; t < THREADS; t++) begin
      if (r_halted[t] && (in_tid == TID_W'(t))) w_halt_hit = 1'b1;
    end
    // Accepted words of a halted or flushed thread are consumed but never stored.
    w_push      = in_valid && in_ready && !w_halt_hit && !(flush && (in_tid == flush_tid));
    w_pop       = r_out_valid && out_ready;
    w_out_hit   = flush && (r_out_tid == flush_tid);
    w_skid_hit  = flush && (r_skid_tid == flush_tid);
    w_keep_out  = r_out_valid && !w_pop && !w_out_hit;
    w_keep_skid = r_skid_valid && !w_skid_hit;
  end

  // Output/skid register movement and halted bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_dec    <= '0;
      r_out_pc     <= '0;
      r_out_tid    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_dec   <= '0;
      r_skid_pc    <= '0;
      r_skid_tid   <= '0;
      r_halted     <= '0;
    end else begin
      // A push can only coincide with an empty skid, since in_ready requires it.
      if (w_keep_out) begin
        if (!w_keep_skid) begin
          r_skid_valid <= w_push;
          if (w_push) begin
            r_skid_dec <= w_dec;
            r_skid_pc  <= in_pc;
            r_skid_tid <= in_tid;
          end
        end
      end else if (w_keep_skid) begin
        r_out_valid  <= 1'b1;
        r_out_dec    <= r_skid_dec;
        r_out_pc     <= r_skid_pc;
        r_out_tid    <= r_skid_tid;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid  <= w_push;
        r_skid_valid <= 1'b0;
        if (w_push) begin
          r_out_dec <= w_dec;
          r_out_pc  <= in_pc;
          r_out_tid <= in_tid;
        end
      end

      // Flush of a thread beats a same-cycle illegal emit for that thread.
      for (int unsigned t = 0; t < THREADS; t++) begin
        if (flush && (flush_tid == TID_W'(t))) begin
          r_halted[t] <= 1'b0;
        end else if (w_push && w_dec.illegal && (in_tid == TID_W'(t))) begin
          r_halted[t] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_idu_mt.sv
// Directed self-checking bench for idu_mt.
module tb_idu_mt;
  import idu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [1:0]  in_tid;
  logic        flush;
  logic [1:0]  flush_tid;
  logic        out_valid;
  logic        out_ready;
  decoded_t    out_dec;
  logic [31:0] out_pc;
  logic [1:0]  out_tid;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] ADDI_X1_1 = 32'h0010_0093;

  idu_mt #(.XLEN(32), .THREADS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_tid    (in_tid),
    .flush     (flush),
    .flush_tid (flush_tid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dec   (out_dec),
    .out_pc    (out_pc),
    .out_tid   (out_tid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_tid = '0;
    flush = 1'b0; flush_tid = '0; out_ready = 1'b0;
    tick(); tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_tests++; if (out_dec !== decoded_t'('0)) begin n_fail++; $display("FAIL reset_out_dec got %h want 0", out_dec); end
    n_tests++; if (out_pc !== 32'h0 || out_tid !== 2'd0) begin n_fail++; $display("FAIL reset_pc_tid got %h/%0d want 0/0", out_pc, out_tid); end
    rst = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_decode();
    logic [31:0] ins [6];
    decoded_t    exp [6];
    ins[0] = 32'hFFF0_0293;  // addi x5,x0,-1
    exp[0] = '{rs1_en:1'b1, rs2_en:1'b0, rd_en:1'b1, rs1_addr:5'd0, rs2_addr:5'd0, rd_addr:5'd5,
               imm:32'hFFFF_FFFF, op_class:CLS_OP_IMM, fn3:3'b000, alt:1'b1, illegal:1'b0};
    ins[1] = 32'hFFDF_F06F;  // jal x0,-4
    exp[1] = '{rs1_en:1'b0, rs2_en:1'b0, rd_en:1'b0, rs1_addr:5'd0, rs2_addr:5'd0, rd_addr:5'd0,
               imm:32'hFFFF_FFFC, op_class:CLS_JAL, fn3:3'b111, alt:1'b1, illegal:1'b0};
    ins[2] = 32'hFE20_AC23;  // sw x2,-8(x1)
    exp[2] = '{rs1_en:1'b1, rs2_en:1'b1, rd_en:1'b0, rs1_addr:5'd1, rs2_addr:5'd2, rd_addr:5'd0,
               imm:32'hFFFF_FFF8, op_class:CLS_STORE, fn3:3'b010, alt:1'b1, illegal:1'b0};
    ins[3] = 32'h1234_50B7;  // lui x1,0x12345
    exp[3] = '{rs1_en:1'b0, rs2_en:1'b0, rd_en:1'b1, rs1_addr:5'd0, rs2_addr:5'd0, rd_addr:5'd1,
               imm:32'h1234_5000, op_class:CLS_LUI, fn3:3'b101, alt:1'b0, illegal:1'b0};
    ins[4] = 32'h0052_1193;  // slli x3,x4,5
    exp[4] = '{rs1_en:1'b1, rs2_en:1'b0, rd_en:1'b1, rs1_addr:5'd4, rs2_addr:5'd0, rd_addr:5'd3,
               imm:32'h0000_0005, op_class:CLS_OP_IMM, fn3:3'b001, alt:1'b0, illegal:1'b0};
    ins[5] = 32'h4031_00B3;  // sub x1,x2,x3
    exp[5] = '{rs1_en:1'b1, rs2_en:1'b1, rd_en:1'b1, rs1_addr:5'd2, rs2_addr:5'd3, rd_addr:5'd1,
               imm:32'h0, op_class:CLS_OP, fn3:3'b000, alt:1'b1, illegal:1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_tid = 2'd0; in_instr = ins[i]; in_pc = 32'h100 + 32'(i * 4);
      tick();
      in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(i * 4) || out_tid !== 2'd0)
        begin n_fail++; $display("FAIL dec%0d_valid_pc got v=%b pc=%h tid=%0d want v=1 pc=%h tid=0", i, out_valid, out_pc, out_tid, 32'h100 + 32'(i * 4)); end
      n_tests++; if (out_dec !== exp[i])
        begin n_fail++; $display("FAIL dec%0d_word got %h want %h", i, out_dec, exp[i]); end
    end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dec_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got[$];
    logic        acc;
    out_ready = 1'b0; in_valid = 1'b1; in_tid = 2'd0; in_instr = ADDI_X1_1; in_pc = 32'h200;
    tick();
    n_tests++; if (in_ready !== 1'b1 || out_pc !== 32'h200) begin n_fail++; $display("FAIL bp_first got rdy=%b pc=%h want 1/200", in_ready, out_pc); end
    in_pc = 32'h204;
    tick();
    n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h200)
      begin n_fail++; $display("FAIL bp_skid got rdy=%b v=%b pc=%h want 0/1/200", in_ready, out_valid, out_pc); end
    in_pc = 32'h208;
    tick();
    n_tests++; if (in_ready !== 1'b0 || out_pc !== 32'h200)
      begin n_fail++; $display("FAIL bp_hold got rdy=%b pc=%h want 0/200", in_ready, out_pc); end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      acc = in_valid && in_ready;
      if (out_valid && out_ready) got.push_back(out_pc);
      tick();
      if (acc) in_valid = 1'b0;
    end
    n_tests++; if (got.size() != 3) begin n_fail++; $display("FAIL bp_count got %0d want 3", got.size()); end
    n_tests++; if (got.size() != 3 || got[0] !== 32'h200 || got[1] !== 32'h204 || got[2] !== 32'h208)
      begin n_fail++; $display("FAIL bp_order got %p want 200,204,208", got); end
  endtask

  task automatic test_halt();
    decoded_t ill;
    ill = '0; ill.illegal = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_tid = 2'd2; in_instr = 32'h0; in_pc = 32'h300;
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_dec !== ill || out_tid !== 2'd2 || out_pc !== 32'h300)
      begin n_fail++; $display("FAIL halt_illegal got v=%b dec=%h tid=%0d pc=%h want 1/%h/2/300", out_valid, out_dec, out_tid, out_pc, ill); end
    in_instr = ADDI_X1_1; in_pc = 32'h304;
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_drop got v=%b want 0", out_valid); end
    in_tid = 2'd1; in_pc = 32'h308;
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_tid !== 2'd1 || out_pc !== 32'h308)
      begin n_fail++; $display("FAIL halt_other got v=%b tid=%0d pc=%h want 1/1/308", out_valid, out_tid, out_pc); end
    in_valid = 1'b0; flush = 1'b1; flush_tid = 2'd2;
    tick();
    flush = 1'b0; in_valid = 1'b1; in_tid = 2'd2; in_pc = 32'h30C;
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || out_tid !== 2'd2 || out_dec.illegal !== 1'b0 || out_pc !== 32'h30C)
      begin n_fail++; $display("FAIL halt_release got v=%b tid=%0d ill=%b pc=%h want 1/2/0/30c", out_valid, out_tid, out_dec.illegal, out_pc); end
    tick();
    in_valid = 1'b1; in_tid = 2'd3; in_instr = 32'hFFFF_FFFF; in_pc = 32'h310; flush = 1'b1; flush_tid = 2'd3;
    tick();
    flush = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_wins_drop got v=%b want 0", out_valid); end
    in_instr = ADDI_X1_1; in_pc = 32'h314;
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || out_tid !== 2'd3 || out_dec.illegal !== 1'b0)
      begin n_fail++; $display("FAIL flush_wins_nohalt got v=%b tid=%0d ill=%b want 1/3/0", out_valid, out_tid, out_dec.illegal); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = ADDI_X1_1; in_tid = 2'd0; in_pc = 32'h400;
    tick();
    in_tid = 2'd1; in_pc = 32'h404;
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_tid !== 2'd0 || in_ready !== 1'b0)
      begin n_fail++; $display("FAIL flush_setup got tid=%0d rdy=%b want 0/0", out_tid, in_ready); end
    flush = 1'b1; flush_tid = 2'd0;
    tick();
    flush = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || out_tid !== 2'd1 || out_pc !== 32'h404 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL flush_out got v=%b tid=%0d pc=%h rdy=%b want 1/1/404/1", out_valid, out_tid, out_pc, in_ready); end
    out_ready = 1'b1;
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_drain got v=%b want 0", out_valid); end
    out_ready = 1'b0; in_valid = 1'b1; in_tid = 2'd0; in_pc = 32'h410;
    tick();
    in_tid = 2'd1; in_pc = 32'h414;
    tick();
    in_valid = 1'b0; flush = 1'b1; flush_tid = 2'd1;
    tick();
    flush = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h410 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL flush_skid got v=%b pc=%h rdy=%b want 1/410/1", out_valid, out_pc, in_ready); end
    out_ready = 1'b1;
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_skid_drain got v=%b want 0", out_valid); end
    out_ready = 1'b0; in_valid = 1'b1; in_tid = 2'd0; in_pc = 32'h420;
    tick();
    in_pc = 32'h424;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0)
      begin n_fail++; $display("FAIL midreset got v=%b rdy=%b want 0/0", out_valid, in_ready); end
    rst = 1'b0;
    tick();
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL midreset_after got v=%b rdy=%b want 0/1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_halt();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
